opcode_decoder: RTL and testbench

OPCODE_DECODER -- requirements
Module: opcode_decoder

---
 rtl/opcode_decoder_if.sv | 21 ++
 rtl/opcode_decoder.sv | 74 +++++++
 tb/tb_opcode_decoder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/opcode_decoder_if.sv
// Opcode decoder bus: opcode byte in, registered state code and illegal flag out.
// The master drives the opcode; the slave (the decoder) returns the decode.
interface opcode_decoder_if #(
    parameter int unsigned STATE_W = 5
);
    logic [7:0]         i_opcode;
    logic [STATE_W-1:0] decoded_state;
    logic               o_illegal;

    modport master (
        output i_opcode,
        input  decoded_state,
        input  o_illegal
    );

    modport slave (
        input  i_opcode,
        output decoded_state,
        output o_illegal
    );
endinterface

// File: rtl/opcode_decoder.sv
// Opcode decoder for the control unit's decode step.
// Maps the opcode byte to a next-state code one cycle later and flags unknown opcodes.
// Build option: define DECODER_RETI_EN to decode RETI (0x32) to state 17;
// without it, RETI is treated as an illegal opcode.
// Only STATE_W = 5 is supported.
module opcode_decoder #(
    parameter int unsigned STATE_W = 5
) (
    input logic            i_clk,
    input logic            i_rst,
    opcode_decoder_if.slave bus
);

    localparam logic [STATE_W-1:0] StStart = STATE_W'(0);
    localparam logic [STATE_W-1:0] StAdd   = STATE_W'(5);
    localparam logic [STATE_W-1:0] StSubb  = STATE_W'(6);
    localparam logic [STATE_W-1:0] StAddc  = STATE_W'(7);
    localparam logic [STATE_W-1:0] StAnl   = STATE_W'(8);
    localparam logic [STATE_W-1:0] StOrl   = STATE_W'(9);
    localparam logic [STATE_W-1:0] StXrl   = STATE_W'(10);
    localparam logic [STATE_W-1:0] StMovA  = STATE_W'(11);
    localparam logic [STATE_W-1:0] StMovFa = STATE_W'(12);
    localparam logic [STATE_W-1:0] StJc    = STATE_W'(13);
    localparam logic [STATE_W-1:0] StJnc   = STATE_W'(14);
    localparam logic [STATE_W-1:0] StJz    = STATE_W'(15);
    localparam logic [STATE_W-1:0] StJnz   = STATE_W'(16);
`ifdef DECODER_RETI_EN
    localparam logic [STATE_W-1:0] StReti  = STATE_W'(17);
`endif

    logic [STATE_W-1:0] state_d;
    logic               illegal_d;

    // Combinational table lookup; low 3 bits are don't-care for the Rn forms.
    always_comb begin
        state_d   = StStart;
        illegal_d = 1'b0;
        casez (bus.i_opcode)
            8'b0010_1???, 8'h25, 8'h24: state_d = StAdd;
            8'b1001_1???, 8'h95, 8'h94: state_d = StSubb;
            8'b0011_1???, 8'h35, 8'h34: state_d = StAddc;
            8'b0101_1???, 8'h55, 8'h54: state_d = StAnl;
            8'b0100_1???, 8'h45, 8'h44: state_d = StOrl;
            8'b0110_1???, 8'h65, 8'h64: state_d = StXrl;
            8'b1110_1???, 8'hE5, 8'h74: state_d = StMovA;
            8'b1111_1???, 8'hF5:        state_d = StMovFa;
            8'h40:                      state_d = StJc;
            8'h50:                      state_d = StJnc;
            8'h60:                      state_d = StJz;
            8'h70:                      state_d = StJnz;
`ifdef DECODER_RETI_EN
            8'h32:                      state_d = StReti;
`endif
            // Internal interrupt pseudo-opcode: restart decode, not an error.
            8'hA5:                      state_d = StStart;
            default: begin
                state_d   = StStart;
                illegal_d = 1'b1;
            end
        endcase
    end

    // Register the decode every cycle; synchronous reset overrides decode.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.decoded_state <= StStart;
            bus.o_illegal     <= 1'b0;
        end else begin
            bus.decoded_state <= state_d;
            bus.o_illegal     <= illegal_d;
        end
    end

endmodule

// File: tb/tb_opcode_decoder.sv
// Self-checking bench for opcode_decoder: directed steps plus random opcodes,
// compared against a table-driven reference model.
module tb_opcode_decoder;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    opcode_decoder_if #(.STATE_W(5)) bus ();

    opcode_decoder #(.STATE_W(5)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Instruction classes: Rn block base, direct form, immediate form (-1 if none), code.
    int rn_base [8] = '{'h28, 'h98, 'h38, 'h58, 'h48, 'h68, 'hE8, 'hF8};
    int direct  [8] = '{'h25, 'h95, 'h35, 'h55, 'h45, 'h65, 'hE5, 'hF5};
    int immed   [8] = '{'h24, 'h94, 'h34, 'h54, 'h44, 'h64, 'h74, -1};
    int code    [8] = '{5, 6, 7, 8, 9, 10, 11, 12};

    function automatic void ref_decode(input logic [7:0] op, output logic [4:0] st,
                                       output logic ill);
        int o;
        o   = int'(op);
        st  = 5'd0;
        ill = 1'b1;
        for (int r = 0; r < 8; r++) begin
            if ((o / 8) * 8 == rn_base[r] || o == direct[r] || o == immed[r]) begin
                st  = 5'(code[r]);
                ill = 1'b0;
            end
        end
        // JC, JNC, JZ, JNZ at 0x40, 0x50, 0x60, 0x70.
        for (int j = 0; j < 4; j++) begin
            if (o == 'h40 + 16 * j) begin
                st  = 5'(13 + j);
                ill = 1'b0;
            end
        end
        if (o == 'hA5) ill = 1'b0;
`ifdef DECODER_RETI_EN
        if (o == 'h32) begin
            st  = 5'd17;
            ill = 1'b0;
        end
`endif
    endfunction

    // One cycle: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic [7:0] op, input logic rst_v, input string tag);
        logic [4:0] exp_st;
        logic       exp_ill;
        @(negedge i_clk);
        bus.i_opcode = op;
        i_rst        = rst_v;
        @(posedge i_clk);
        #1;
        if (rst_v) begin
            exp_st  = 5'd0;
            exp_ill = 1'b0;
        end else begin
            ref_decode(op, exp_st, exp_ill);
        end
        checks++;
        assert (bus.decoded_state === exp_st) else begin
            errors++;
            $error("FAIL %s state op=%02h: observed %0d expected %0d",
                   tag, op, bus.decoded_state, exp_st);
        end
        checks++;
        assert (bus.o_illegal === exp_ill) else begin
            errors++;
            $error("FAIL %s illegal op=%02h: observed %0b expected %0b",
                   tag, op, bus.o_illegal, exp_ill);
        end
        checks++;
        assert (bus.decoded_state <= 5'd17) else begin
            errors++;
            $error("FAIL %s range op=%02h: observed %0d expected <=17",
                   tag, op, bus.decoded_state);
        end
    endtask

    initial begin
        bus.i_opcode = 8'h28;

        // Reset holds outputs at zero, then release decodes ADD Rn.
        step(8'h28, 1'b1, "reset");
        step(8'h28, 1'b1, "reset_hold");
        step(8'h28, 1'b0, "reset_release");

        // Rn sweeps.
        for (int n = 0; n < 8; n++) step(8'(8'h28 + n), 1'b0, "rn_add");
        for (int n = 0; n < 8; n++) step(8'(8'h98 + n), 1'b0, "rn_subb");
        for (int n = 0; n < 8; n++) step(8'(8'hE8 + n), 1'b0, "rn_mov_to_a");
        for (int n = 0; n < 8; n++) step(8'(8'hF8 + n), 1'b0, "rn_mov_from_a");

        // Direct / immediate forms.
        step(8'h24, 1'b0, "imm_add");
        step(8'h35, 1'b0, "dir_addc");
        step(8'h54, 1'b0, "imm_anl");
        step(8'h45, 1'b0, "dir_orl");
        step(8'h64, 1'b0, "imm_xrl");
        step(8'h74, 1'b0, "imm_mov");
        step(8'hF5, 1'b0, "dir_mov_from_a");

        // Jumps and special codes.
        step(8'h40, 1'b0, "jc");
        step(8'h50, 1'b0, "jnc");
        step(8'h60, 1'b0, "jz");
        step(8'h70, 1'b0, "jnz");
        step(8'hA5, 1'b0, "interrupt");
        step(8'h00, 1'b0, "illegal_00");
        step(8'h32, 1'b0, "reti");

        // Back-to-back with a mid-stream reset.
        step(8'h25, 1'b0, "b2b_0");
        step(8'h40, 1'b0, "b2b_1");
        step(8'hFF, 1'b0, "b2b_2");
        step(8'h95, 1'b1, "b2b_midreset");
        step(8'h95, 1'b0, "b2b_after_reset");

        // Exhaustive sweep of all opcodes.
        for (int o = 0; o < 256; o++) step(8'(o), 1'b0, "sweep");

        // Random opcodes with occasional resets.
        for (int i = 0; i < 300; i++) begin
            step(8'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
